ssio_ddr_in_delay_cal: RTL and testbench

Calibration controller for the source-synchronous DDR input path. It sweeps the input-delay tap across its full range while the link partner drives a known training pattern. At each tap it checks the captured rising/falling-edge words against that pattern, then finds the longest contiguous run of passing taps and loads the tap at its centre. It runs in the captured-clock domain, next to the DDR input block, and drives that block's delay configuration.

---
 rtl/ssio_ddr_in_delay_cal.sv | 181 ++++++++++++++++++
 tb/tb_ssio_ddr_in_delay_cal.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ssio_ddr_in_delay_cal.sv
// Sweeps the DDR input delay tap, scores each tap against a training pattern and loads the centre of the widest passing window.
// Latency: start -> first load strobe 1 cycle, final strobe after (MAX_TAP+1)*(SETTLE+CHECK+2) more; no backpressure, start ignored while busy.
module ssio_ddr_in_delay_cal #(
    parameter int                WIDTH         = 1,
    parameter int                TAP_WIDTH     = 5,
    parameter int                MAX_TAP       = 31,
    parameter int                INIT_TAP      = 0,
    parameter int                SETTLE_CYCLES = 16,
    parameter int                CHECK_CYCLES  = 64,
    parameter logic [WIDTH-1:0]  PATTERN_Q1    = {WIDTH{1'b1}},
    parameter logic [WIDTH-1:0]  PATTERN_Q2    = {WIDTH{1'b0}}
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     q1,
    input  logic [WIDTH-1:0]     q2,
    output logic [TAP_WIDTH-1:0] delay_value,
    output logic                 delay_load,
    output logic                 busy,
    output logic                 locked,
    output logic                 error,
    output logic [TAP_WIDTH-1:0] window_start,
    output logic [TAP_WIDTH:0]   window_len
);
    localparam int CNT_MAX = (SETTLE_CYCLES > CHECK_CYCLES) ? SETTLE_CYCLES : CHECK_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0]     SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]     CHECK_LAST  = CNT_W'(CHECK_CYCLES - 1);
    localparam logic [CNT_W-1:0]     CNT_ONE     = CNT_W'(1);
    localparam logic [TAP_WIDTH-1:0] TAP_LAST    = TAP_WIDTH'(MAX_TAP);
    localparam logic [TAP_WIDTH-1:0] TAP_INIT    = TAP_WIDTH'(INIT_TAP);
    localparam logic [TAP_WIDTH-1:0] TAP_ONE     = TAP_WIDTH'(1);
    localparam logic [TAP_WIDTH:0]   LEN_ONE     = (TAP_WIDTH+1)'(1);

    typedef enum logic [2:0] {IDLE, LOAD, SETTLE, CHECK, EVAL, FINAL, DONE, FAIL} state_t;

    state_t                 state, state_nx;
    logic [TAP_WIDTH-1:0]   tap, tap_nx;
    logic [CNT_W-1:0]       cnt, cnt_nx;
    logic                   tap_fail, fail_nx;
    logic [TAP_WIDTH-1:0]   cur_start, cur_start_nx, best_start, best_start_nx;
    logic [TAP_WIDTH:0]     cur_len, cur_len_nx, best_len, best_len_nx;
    logic [TAP_WIDTH:0]     half_len;
    logic [TAP_WIDTH-1:0]   value_nx, win_start_nx;
    logic [TAP_WIDTH:0]     win_len_nx;
    logic                   load_nx, busy_nx, locked_nx, error_nx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            tap          <= '0;
            cnt          <= '0;
            tap_fail     <= 1'b0;
            cur_start    <= '0;
            cur_len      <= '0;
            best_start   <= '0;
            best_len     <= '0;
            delay_value  <= TAP_INIT;
            delay_load   <= 1'b0;
            busy         <= 1'b0;
            locked       <= 1'b0;
            error        <= 1'b0;
            window_start <= '0;
            window_len   <= '0;
        end else begin
            state        <= state_nx;
            tap          <= tap_nx;
            cnt          <= cnt_nx;
            tap_fail     <= fail_nx;
            cur_start    <= cur_start_nx;
            cur_len      <= cur_len_nx;
            best_start   <= best_start_nx;
            best_len     <= best_len_nx;
            delay_value  <= value_nx;
            delay_load   <= load_nx;
            busy         <= busy_nx;
            locked       <= locked_nx;
            error        <= error_nx;
            window_start <= win_start_nx;
            window_len   <= win_len_nx;
        end
    end

    // Outputs are registered, so every strobe is decided one state early.
    always_comb begin
        state_nx      = state;
        tap_nx        = tap;
        cnt_nx        = cnt;
        fail_nx       = tap_fail;
        cur_start_nx  = cur_start;
        cur_len_nx    = cur_len;
        best_start_nx = best_start;
        best_len_nx   = best_len;
        value_nx      = delay_value;
        load_nx       = 1'b0;
        busy_nx       = busy;
        locked_nx     = locked;
        error_nx      = error;
        win_start_nx  = window_start;
        win_len_nx    = window_len;
        half_len      = '0;
        case (state)
            IDLE, DONE, FAIL: begin
                if (start) begin
                    tap_nx        = '0;
                    cur_start_nx  = '0;
                    cur_len_nx    = '0;
                    best_start_nx = '0;
                    best_len_nx   = '0;
                    locked_nx     = 1'b0;
                    error_nx      = 1'b0;
                    busy_nx       = 1'b1;
                    load_nx       = 1'b1;
                    value_nx      = '0;
                    state_nx      = LOAD;
                end
            end
            LOAD: begin
                cnt_nx   = '0;
                fail_nx  = 1'b0;
                state_nx = SETTLE;
            end
            SETTLE: begin
                if (cnt == SETTLE_LAST) begin
                    cnt_nx   = '0;
                    state_nx = CHECK;
                end else begin
                    cnt_nx = cnt + CNT_ONE;
                end
            end
            CHECK: begin
                if ((q1 != PATTERN_Q1) || (q2 != PATTERN_Q2)) fail_nx = 1'b1;
                if (cnt == CHECK_LAST) begin
                    cnt_nx   = '0;
                    state_nx = EVAL;
                end else begin
                    cnt_nx = cnt + CNT_ONE;
                end
            end
            EVAL: begin
                if (!tap_fail) begin
                    if (cur_len == '0) cur_start_nx = tap;
                    cur_len_nx = cur_len + LEN_ONE;
                    // Strict compare keeps the lowest window on a tie.
                    if (cur_len_nx > best_len) begin
                        best_start_nx = cur_start_nx;
                        best_len_nx   = cur_len_nx;
                    end
                end else begin
                    cur_len_nx = '0;
                end
                load_nx = 1'b1;
                if (tap == TAP_LAST) begin
                    half_len = (best_len_nx - LEN_ONE) >> 1;
                    value_nx = (best_len_nx == '0) ? TAP_INIT
                                                   : best_start_nx + half_len[TAP_WIDTH-1:0];
                    state_nx = FINAL;
                end else begin
                    tap_nx   = tap + TAP_ONE;
                    value_nx = tap_nx;
                    state_nx = LOAD;
                end
            end
            FINAL: begin
                busy_nx = 1'b0;
                if (best_len == '0) begin
                    error_nx = 1'b1;
                    state_nx = FAIL;
                end else begin
                    locked_nx    = 1'b1;
                    win_start_nx = best_start;
                    win_len_nx   = best_len;
                    state_nx     = DONE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end
endmodule

// File: tb/tb_ssio_ddr_in_delay_cal.sv
// Bench for ssio_ddr_in_delay_cal: a link-partner model drives pattern/garbage per tap and a window model predicts the result.
module tb_ssio_ddr_in_delay_cal;
    localparam int W       = 2;
    localparam int TW      = 5;
    localparam int MAXT    = 31;
    localparam int INIT    = 5;
    localparam int S       = 16;
    localparam int C       = 64;
    localparam int PER     = S + C + 2;
    localparam int FINAL_K = 1 + (MAXT + 1) * PER;
    localparam logic [W-1:0] P1 = {W{1'b1}};
    localparam logic [W-1:0] P2 = {W{1'b0}};
    localparam logic [3*TW+4:0] RST_VEC = {TW'(INIT), 4'b0000, {(2*TW+1){1'b0}}};

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [W-1:0]  q1, q2;
    logic [TW-1:0] delay_value, window_start;
    logic          delay_load, busy, locked, error;
    logic [TW:0]   window_len;

    ssio_ddr_in_delay_cal #(
        .WIDTH(W), .TAP_WIDTH(TW), .MAX_TAP(MAXT), .INIT_TAP(INIT),
        .SETTLE_CYCLES(S), .CHECK_CYCLES(C), .PATTERN_Q1(P1), .PATTERN_Q2(P2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .q1(q1), .q2(q2),
        .delay_value(delay_value), .delay_load(delay_load), .busy(busy),
        .locked(locked), .error(error), .window_start(window_start), .window_len(window_len)
    );

    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail = 0;
    logic [31:0] pass_mask = '1;
    int          fail_mode = 0;
    int          strobes[$];
    int          strobe_cyc[$];
    int          done_cyc;
    bit          b2b, first_load, first_busy, err_after, lock_after;
    int          first_val;

    // Link partner: garbage outside the compare window, pattern inside it unless the tap is marked bad.
    initial begin : driver
        int cur_tap, off, ci, bad_idx;
        logic [2*W-1:0] flip;
        cur_tap = 0; off = 1000; bad_idx = 0; q1 = P1; q2 = P2;
        forever begin
            @(negedge clk);
            if (delay_load) begin
                cur_tap = int'(delay_value);
                off = 0;
                bad_idx = $urandom_range(C - 1, 0);
            end else if (off < 1000) begin
                off++;
            end
            ci = off - (S + 1);
            q1 = W'($urandom);
            q2 = W'($urandom);
            if (ci >= 0 && ci < C) begin
                q1 = P1; q2 = P2;
                if (!pass_mask[cur_tap] &&
                    ((fail_mode == 1) ? (ci == C - 1) : (ci == bad_idx || $urandom_range(7, 0) == 0))) begin
                    flip = '0;
                    flip[$urandom_range(2*W - 1, 0)] = 1'b1;
                    {q1, q2} = {P1, P2} ^ flip;
                end
            end
        end
    end

    function automatic void model(input logic [31:0] m, output int tap, output int ws, output int wl);
        ws = 0; wl = 0;
        for (int s = 0; s <= MAXT; s++) begin
            int l;
            l = 0;
            while (s + l <= MAXT && m[s + l]) l++;
            if (l > wl) begin wl = l; ws = s; end
        end
        tap = (wl == 0) ? INIT : ws + (wl - 1) / 2;
    endfunction

    function automatic logic [31:0] rng(input int lo, input int hi);
        logic [31:0] r;
        r = '0;
        for (int i = lo; i <= hi; i++) r[i] = 1'b1;
        return r;
    endfunction

    // Pulses start and records every strobe until busy drops; k=1 is the cycle after start.
    task automatic run_cal(input logic [31:0] m, input int mode, input int mid_start);
        bit prev;
        pass_mask = m; fail_mode = mode;
        strobes.delete(); strobe_cyc.delete();
        done_cyc = -1; b2b = 0; prev = 0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        first_load = delay_load; first_val = int'(delay_value); first_busy = busy;
        err_after = error; lock_after = locked;
        for (int k = 1; k < 6000; k++) begin
            if (k > 1) @(negedge clk);
            start = (k == mid_start);
            if (delay_load) begin
                strobes.push_back(int'(delay_value));
                strobe_cyc.push_back(k);
                if (prev) b2b = 1;
            end
            prev = delay_load;
            if (!busy) begin done_cyc = k; break; end
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        int act;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_tests++;
        if ({delay_value, delay_load, busy, locked, error, window_start, window_len} !== RST_VEC) begin
            n_fail++;
            $display("FAIL reset_values: got %h, expected %h",
                     {delay_value, delay_load, busy, locked, error, window_start, window_len}, RST_VEC);
        end
        rst_n = 1'b1;
        act = 0;
        repeat (40) begin @(negedge clk); if (delay_load || busy) act++; end
        n_tests++;
        if (act !== 0) begin n_fail++; $display("FAIL reset_idle: got %0d active cycles, expected 0", act); end
    endtask

    task automatic test_full_sweep();
        int bad;
        run_cal('1, 0, 0);
        n_tests++;
        if ({first_load, first_busy} !== 2'b11) begin n_fail++; $display("FAIL first_strobe: got load/busy %b%b, expected 11", first_load, first_busy); end
        n_tests++;
        if (first_val !== 0) begin n_fail++; $display("FAIL first_value: got %0d, expected 0", first_val); end
        n_tests++;
        if (strobes.size() !== 33) begin n_fail++; $display("FAIL strobe_count: got %0d, expected 33", strobes.size()); end
        bad = 0;
        for (int i = 0; i < 32 && i < strobes.size(); i++) if (strobes[i] != i) bad++;
        n_tests++;
        if (bad !== 0) begin n_fail++; $display("FAIL sweep_taps: got %0d wrong taps, expected 0", bad); end
        n_tests++;
        if (strobes.size() == 0 || strobes[$] !== 15) begin n_fail++; $display("FAIL full_final_tap: got %0d, expected 15", strobes.size() ? strobes[$] : -1); end
        n_tests++;
        if (strobe_cyc.size() == 0 || strobe_cyc[$] !== FINAL_K) begin n_fail++; $display("FAIL final_cycle: got %0d, expected %0d", strobe_cyc.size() ? strobe_cyc[$] : -1, FINAL_K); end
        n_tests++;
        if (done_cyc !== FINAL_K + 1) begin n_fail++; $display("FAIL done_cycle: got %0d, expected %0d", done_cyc, FINAL_K + 1); end
        n_tests++;
        if (b2b !== 1'b0) begin n_fail++; $display("FAIL load_back_to_back: got %0d, expected 0", b2b); end
        n_tests++;
        if ({locked, error, window_start, window_len} !== {1'b1, 1'b0, TW'(0), (TW+1)'(32)}) begin
            n_fail++;
            $display("FAIL full_result: got locked %0d error %0d start %0d len %0d, expected 1 0 0 32", locked, error, window_start, window_len);
        end
    endtask

    task automatic test_window(input string name, input logic [31:0] m, input int mode);
        int et, ews, ewl;
        model(m, et, ews, ewl);
        run_cal(m, mode, 0);
        n_tests++;
        if (done_cyc !== FINAL_K + 1) begin n_fail++; $display("FAIL %s done: got %0d, expected %0d", name, done_cyc, FINAL_K + 1); end
        n_tests++;
        if (lock_after !== 1'b0) begin n_fail++; $display("FAIL %s lock_cleared: got %0d, expected 0", name, lock_after); end
        n_tests++;
        if (strobes.size() !== 33 || strobes[$] !== et) begin
            n_fail++;
            $display("FAIL %s final_tap: got %0d strobes last %0d, expected 33 last %0d", name, strobes.size(), strobes.size() ? strobes[$] : -1, et);
        end
        n_tests++;
        if ({locked, error} !== {ewl > 0, ewl == 0}) begin n_fail++; $display("FAIL %s status: got locked %0d error %0d, expected %0d %0d", name, locked, error, ewl > 0, ewl == 0); end
        if (ewl > 0) begin
            n_tests++;
            if (int'(window_start) !== ews || int'(window_len) !== ewl) begin
                n_fail++;
                $display("FAIL %s window: got %0d/%0d, expected %0d/%0d", name, window_start, window_len, ews, ewl);
            end
        end
    endtask

    task automatic test_never_pass();
        test_window("never_pass", '0, 0);
        n_tests++;
        if (strobes.size() == 0 || strobes[$] !== INIT) begin n_fail++; $display("FAIL init_tap_on_error: got %0d, expected %0d", strobes.size() ? strobes[$] : -1, INIT); end
        test_window("after_error", rng(4, 9), 0);
        n_tests++;
        if ({err_after, first_busy} !== 2'b01) begin n_fail++; $display("FAIL error_cleared: got error/busy %b%b, expected 01", err_after, first_busy); end
    endtask

    task automatic test_start_while_busy();
        run_cal('1, 0, 1000);
        n_tests++;
        if (strobes.size() !== 33 || done_cyc !== FINAL_K + 1) begin
            n_fail++;
            $display("FAIL start_while_busy: got %0d strobes done %0d, expected 33 done %0d", strobes.size(), done_cyc, FINAL_K + 1);
        end
    endtask

    task automatic test_reset_mid_sweep();
        int act;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (7 * PER + S + 20) @(negedge clk);
        n_tests++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL busy_mid_sweep: got %0d, expected 1", busy); end
        #1 rst_n = 1'b0;
        #1;
        n_tests++;
        if ({delay_value, delay_load, busy, locked, error, window_start, window_len} !== RST_VEC) begin
            n_fail++;
            $display("FAIL async_reset: got %h, expected %h",
                     {delay_value, delay_load, busy, locked, error, window_start, window_len}, RST_VEC);
        end
        #10 rst_n = 1'b1;
        act = 0;
        repeat (100) begin @(negedge clk); if (delay_load || busy) act++; end
        n_tests++;
        if (act !== 0) begin n_fail++; $display("FAIL no_restart_after_reset: got %0d active cycles, expected 0", act); end
    endtask

    initial begin
        test_reset();
        test_full_sweep();
        test_window("win_10_20", rng(10, 20), 0);
        test_window("two_windows", rng(3, 6) | rng(20, 27), 0);
        test_window("tie", rng(2, 5) | rng(10, 13), 0);
        test_window("late_glitch_tap12", ~rng(12, 12), 1);
        for (int i = 0; i < 3; i++) begin
            logic [31:0] m;
            m = (i == 0) ? $urandom : (i == 1) ? ($urandom | $urandom) : ($urandom & $urandom);
            test_window("random", m, 0);
        end
        test_never_pass();
        test_start_while_busy();
        test_reset_mid_sweep();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
